// File: rtl/mode_arbiter.sv
// Round-robin arbiter for the shared mode resource: one owner at a time, bounded hold,
// and a fixed idle gap before the next owner is picked.
module mode_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         grant,
  output logic                 m,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  localparam int OW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_GAP
  } state_t;

  state_t          state_reg,   state_next;
  logic [N-1:0]    grant_reg,   grant_next;
  logic            m_reg;
  logic [OW-1:0]   owner_reg,   owner_next;
  logic            timeout_reg, timeout_next;
  logic [OW-1:0]   ptr_reg,     ptr_next;
  logic [HW-1:0]   hold_reg,    hold_next;
  logic [GW-1:0]   gap_reg,     gap_next;

  // rot[i] is the request of requester (ptr+i) mod N, so the lowest set bit wins.
  logic [N-1:0]    rot;
  logic [OW-1:0]   win_off;
  logic [OW-1:0]   win;
  logic [OW-1:0]   win_succ;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [OW-1:0] src;
    assign src     = OW'((int'(ptr_reg) + gi) % N);
    assign rot[gi] = req[src];
  end

  always_comb begin
    win_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) win_off = OW'(i);
    end
    win      = OW'((int'(ptr_reg) + int'(win_off)) % N);
    win_succ = OW'((int'(win) + 1) % N);
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    owner_next   = owner_reg;
    timeout_next = 1'b0;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    gap_next     = gap_reg;

    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          state_next = ST_OWN;
          grant_next = N'(1) << win;
          owner_next = win;
          ptr_next   = win_succ;
          hold_next  = '0;
        end
      end

      ST_OWN: begin
        // A release in the same cycle as the hold limit wins over the timeout.
        if (rel[owner_reg]) begin
          state_next = ST_GAP;
          grant_next = '0;
          gap_next   = '0;
        end else if (MAX_HOLD > 0 && hold_reg == HOLD_LAST) begin
          state_next   = ST_GAP;
          grant_next   = '0;
          gap_next     = '0;
          timeout_next = 1'b1;
        end else if (hold_reg != {HW{1'b1}}) begin
          hold_next = hold_reg + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      m_reg       <= 1'b0;
      owner_reg   <= '0;
      timeout_reg <= 1'b0;
      ptr_reg     <= '0;
      hold_reg    <= '0;
      gap_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      m_reg       <= |grant_next;
      owner_reg   <= owner_next;
      timeout_reg <= timeout_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      gap_reg     <= gap_next;
    end
  end

  assign grant   = grant_reg;
  assign m       = m_reg;
  assign owner   = owner_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_mode_arbiter.sv
// Bench for mode_arbiter: fixed vector table, hand-written corner sequences and random
// traffic, all checked every cycle against a cycle-level reference model.
module tb_mode_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;
  localparam int GAP      = 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = '0;
  logic [3:0] rel   = '0;
  logic [3:0] grant;
  logic       m;
  logic [1:0] owner;
  logic       timeout;

  int total  = 0;
  int passed = 0;

  mode_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .grant(grant), .m(m), .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, how long it has held it,
  // how many gap cycles remain, and where the round-robin search starts.
  bit mo_owned = 0;
  int mo_owner = 0;
  int mo_held  = 0;
  int mo_gap   = 0;
  int mo_ptr   = 0;
  bit mo_to    = 0;

  task automatic model_step(input logic r, input logic [3:0] q, input logic [3:0] l);
    bit found;
    mo_to = 0;
    if (r) begin
      mo_owned = 0; mo_owner = 0; mo_held = 0; mo_gap = 0; mo_ptr = 0;
    end else if (mo_owned) begin
      mo_held++;
      if (l[mo_owner]) begin
        mo_owned = 0; mo_gap = GAP;
      end else if (MAX_HOLD > 0 && mo_held == MAX_HOLD) begin
        mo_owned = 0; mo_gap = GAP; mo_to = 1;
      end
    end else if (mo_gap > 0) begin
      mo_gap--;
    end else if (q != 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (mo_ptr + i) % N;
        if (!found && q[c]) begin
          found = 1; mo_owned = 1; mo_owner = c; mo_held = 0; mo_ptr = (c + 1) % N;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 time unit later.
  task automatic cyc(input logic r, input logic [3:0] q, input logic [3:0] l);
    logic [3:0] exp_g;
    reset = r; req = q; rel = l;
    @(posedge clk);
    model_step(r, q, l);
    #1;
    exp_g = mo_owned ? 4'(1 << mo_owner) : 4'b0;
    chk("model", {24'b0, grant, m, owner, timeout}, {24'b0, exp_g, mo_owned, 2'(mo_owner), mo_to});
    chk("invariant", {30'b0, $onehot0(grant), (m == |grant)}, 32'd3);
  endtask

  typedef struct packed {
    logic       r;
    logic [3:0] q;
    logic [3:0] l;
    logic [3:0] g;
    logic       mm;
    logic [1:0] o;
    logic       t;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int seq[$];
    int hi, zeros, held;
    bit saw_to;
    logic [3:0] rel_v;

    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0};
    tbl[3]  = '{1'b0, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'h4, 4'h4, 4'h0, 1'b0, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 4'h8, 4'h8, 1'b1, 2'd3, 1'b0};
    tbl[8]  = '{1'b0, 4'hF, 4'h2, 4'h8, 1'b1, 2'd3, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'h8, 4'h0, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0};
    tbl[16] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 4'h9, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, tbl[i].q, tbl[i].l);
      chk($sformatf("vec%0d", i), {24'b0, grant, m, owner, timeout},
          {24'b0, tbl[i].g, tbl[i].mm, tbl[i].o, tbl[i].t});
      $display("vec %0d: reset=%b req=%b rel=%b -> grant=%b m=%b owner=%0d timeout=%b",
               i, tbl[i].r, tbl[i].q, tbl[i].l, grant, m, owner, timeout);
    end

    // Round robin with every owner releasing after two cycles.
    cyc(1'b1, 4'h0, 4'h0);
    rel_v = '0; zeros = 0; held = 0;
    for (int c = 0; c < 60 && seq.size() < 5; c++) begin
      cyc(1'b0, 4'hF, rel_v);
      if (m) begin
        if (held == 0) begin
          seq.push_back(int'(owner));
          if (seq.size() > 1) chk("rr_gap", zeros, GAP + 1);
          zeros = 0;
        end
        held++;
      end else begin
        zeros++; held = 0;
      end
      rel_v = (m && held == 2) ? grant : 4'h0;
    end
    chk("rr_count", seq.size(), 5);
    for (int i = 0; i < seq.size(); i++) chk($sformatf("rr_owner%0d", i), seq[i], i % N);
    $display("round robin: %0d grants observed", seq.size());

    // Timeout: owner never releases.
    cyc(1'b1, 4'h0, 4'h0);
    cyc(1'b0, 4'h1, 4'h0);
    hi = 1; saw_to = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 4'h1, 4'h0);
      if (!m) begin
        saw_to = timeout;
        break;
      end
      hi++;
    end
    chk("to_hold_cycles", hi, MAX_HOLD);
    chk("to_pulse", {31'b0, saw_to}, 32'd1);
    cyc(1'b0, 4'h1, 4'h0);
    chk("to_pulse_end", {31'b0, timeout}, 32'd0);
    cyc(1'b0, 4'h1, 4'h0);
    chk("to_regrant", {28'b0, grant}, 32'h1);
    $display("timeout: held %0d cycles, regrant=%b", hi, grant);

    // Release in the same cycle as the hold limit, then a non-owner release.
    cyc(1'b1, 4'h0, 4'h0);
    cyc(1'b0, 4'h1, 4'h0);
    repeat (15) cyc(1'b0, 4'h1, 4'h0);
    chk("col_still_owned", {31'b0, m}, 32'd1);
    cyc(1'b0, 4'h1, 4'h1);
    chk("col_grant", {28'b0, grant}, 32'h0);
    chk("col_timeout", {31'b0, timeout}, 32'd0);
    cyc(1'b1, 4'h0, 4'h0);
    cyc(1'b0, 4'h2, 4'h0);
    cyc(1'b0, 4'h2, 4'h8);
    chk("nonowner_rel", {28'b0, grant}, 32'h2);
    $display("collision: release honoured, foreign release ignored, grant=%b", grant);

    // Reset while owner 3 holds; pointer must restart at 0.
    cyc(1'b1, 4'h0, 4'h0);
    cyc(1'b0, 4'h8, 4'h0);
    chk("mr_owner3", {30'b0, owner}, 32'd3);
    cyc(1'b0, 4'h8, 4'h0);
    cyc(1'b1, 4'h9, 4'h0);
    chk("mr_drop", {27'b0, grant, m}, 32'h0);
    cyc(1'b0, 4'h9, 4'h0);
    chk("mr_owner0", {26'b0, grant, owner}, {26'b0, 4'h1, 2'd0});
    $display("mid-op reset: owner=%0d grant=%b", owner, grant);

    // Random traffic against the model.
    cyc(1'b1, 4'h0, 4'h0);
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic [3:0] q, l;
      r = ($urandom_range(0, 199) == 0);
      q = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cyc(r, q, l);
    end
    $display("random: 1500 cycles applied");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
